// File: rtl/gate_seq_ctrl_if.sv
// Signal bundle between the gate test sequencer, the lab control logic and the gate instances.
// master = sequencer side; slave = the control/gate environment that drives start and the gate outputs.
interface gate_seq_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic       a;
  logic       b;
  logic [1:0] vec_idx;
  logic       p_in;
  logic       q_in;
  logic       r_in;
  logic       s_in;
  logic       t_in;
  logic [4:0] err_mask;
  logic [2:0] err_count;

  modport master (
    input  start, p_in, q_in, r_in, s_in, t_in,
    output busy, done, pass, a, b, vec_idx, err_mask, err_count
  );

  modport slave (
    output start, p_in, q_in, r_in, s_in, t_in,
    input  busy, done, pass, a, b, vec_idx, err_mask, err_count
  );
endinterface

// File: rtl/gate_seq_ctrl.sv
// Drives the four {a,b} vectors into the shared-input gate set, holds each for DWELL cycles,
// checks the five gate outputs against golden values on the last dwell cycle and reports the result.
module gate_seq_ctrl #(
  parameter logic [3:0] DWELL = 4'd4
) (
  input  logic            clk,
  input  logic            rst,
  gate_seq_ctrl_if.master bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] golden;
  logic [4:0] observed;
  logic [4:0] mism;
  logic [2:0] next_count;
  logic [1:0] next_idx;

  assign dbg_state = state;

  // Golden values derive from the registered a/b actually presented to the gates.
  always_comb begin
    golden     = {~(bus.a & bus.b), bus.a ^ bus.b, bus.a | bus.b, bus.a & bus.b, ~bus.a};
    observed   = {bus.t_in, bus.s_in, bus.r_in, bus.q_in, bus.p_in};
    mism       = golden ^ observed;
    next_count = bus.err_count + {2'b00, |mism};
    next_idx   = bus.vec_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bus.a         <= 1'b0;
      bus.b         <= 1'b0;
      bus.vec_idx   <= 2'd0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_mask  <= 5'd0;
      bus.err_count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state         <= DRIVE;
            bus.busy      <= 1'b1;
            cnt           <= 4'd0;
            bus.vec_idx   <= 2'd0;
            bus.a         <= 1'b0;
            bus.b         <= 1'b0;
            bus.err_mask  <= 5'd0;
            bus.err_count <= 3'd0;
            bus.pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt == DWELL - 4'd1) begin
            bus.err_mask  <= bus.err_mask | mism;
            bus.err_count <= next_count;
            if (bus.vec_idx == 2'd3) begin
              // Verdict includes the final vector's sample taken on this same edge.
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (next_count == 3'd0);
            end else begin
              bus.vec_idx <= next_idx;
              bus.a       <= next_idx[1];
              bus.b       <= next_idx[0];
              cnt         <= 4'd0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.done    <= 1'b0;
          bus.a       <= 1'b0;
          bus.b       <= 1'b0;
          bus.vec_idx <= 2'd0;
          cnt         <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: gate models with injectable faults, a result scoreboard and
// per-cycle checks of the drive sequence, done timing and reset behaviour for DWELL=4 and DWELL=2.
module tb_gate_seq_ctrl;

  typedef struct packed {
    logic [1:0] st;
    logic       busy;
    logic       done;
    logic       pass;
    logic       a;
    logic       b;
    logic [1:0] vec_idx;
    logic [4:0] err_mask;
    logic [2:0] err_count;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] faults;   // bit0 AND stuck 0, bit1 XOR behaves as OR, bit2 inverter stuck 1
  logic [1:0] st4;
  logic [1:0] st2;
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  gate_seq_ctrl_if bus4 ();
  gate_seq_ctrl_if bus2 ();

  gate_seq_ctrl #(.DWELL(4'd4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .dbg_state(st4));
  gate_seq_ctrl #(.DWELL(4'd2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(st2));

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [4:0] gate_out(input logic a, input logic b, input logic [2:0] f);
    logic p, q, r, s, t;
    p = f[2] ? 1'b1 : ~a;
    q = f[0] ? 1'b0 : (a & b);
    r = a | b;
    s = f[1] ? (a | b) : (a ^ b);
    t = ~(a & b);
    return {t, s, r, q, p};
  endfunction

  assign {bus4.t_in, bus4.s_in, bus4.r_in, bus4.q_in, bus4.p_in} = gate_out(bus4.a, bus4.b, faults);
  assign {bus2.t_in, bus2.s_in, bus2.r_in, bus2.q_in, bus2.p_in} = gate_out(bus2.a, bus2.b, faults);

  // Expected {pass, err_mask, err_count} for a full run with the given faults.
  function automatic logic [8:0] model(input logic [2:0] f);
    logic [4:0] mask, gold, mm;
    logic [2:0] cnt;
    logic [1:0] v2;
    mask = 5'd0;
    cnt  = 3'd0;
    for (int v = 0; v < 4; v++) begin
      v2   = v[1:0];
      gold = {~(v2[1] & v2[0]), v2[1] ^ v2[0], v2[1] | v2[0], v2[1] & v2[0], ~v2[1]};
      mm   = gold ^ gate_out(v2[1], v2[0], f);
      mask = mask | mm;
      if (mm != 5'd0) cnt = cnt + 3'd1;
    end
    return {cnt == 3'd0, mask, cnt};
  endfunction

  function automatic obs_t sample(input bit use2);
    obs_t o;
    if (use2) o = {st2, bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.vec_idx, bus2.err_mask, bus2.err_count};
    else      o = {st4, bus4.busy, bus4.done, bus4.pass, bus4.a, bus4.b, bus4.vec_idx, bus4.err_mask, bus4.err_count};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic set_start(input bit use2, input logic v);
    if (use2) bus2.start = v;
    else      bus4.start = v;
  endtask

  // Called at a negedge in IDLE; start is sampled at the next posedge. hold keeps start high.
  task automatic do_run(input bit use2, input int dwell, input bit hold);
    logic [8:0] exp;
    logic [8:0] got;
    obs_t       o;
    int         vec;
    exp = model(faults);
    exp_q.push_back(exp);
    set_start(use2, 1'b1);
    for (int c = 1; c <= 4 * dwell + 2; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) set_start(use2, 1'b0);
      o = sample(use2);
      if (c <= 4 * dwell) begin
        vec = (c - 1) / dwell;
        chk("busy", o.busy, 1);
        chk("done_low", o.done, 0);
        chk("ab", {o.a, o.b}, vec[1:0]);
        chk("vec_idx", o.vec_idx, vec[1:0]);
        if (c == 1) chk("cleared_on_start", {o.pass, o.err_mask, o.err_count}, 0);
      end else if (c == 4 * dwell + 1) begin
        chk("done_pulse", o.done, 1);
        chk("busy_in_done", o.busy, 0);
        got = {o.pass, o.err_mask, o.err_count};
        if (exp_q.size() == 0) begin
          failures++;
          $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
          chk("result", got, exp_q.pop_front());
        end
      end else begin
        chk("idle_done_low", o.done, 0);
        chk("idle_busy", o.busy, 0);
        chk("idle_state", o.st, 0);
        chk("idle_ab_idx", {o.a, o.b, o.vec_idx}, 0);
        chk("result_held", {o.pass, o.err_mask, o.err_count}, exp);
      end
    end
  endtask

  initial begin
    obs_t o;
    rst        = 1'b1;
    faults     = 3'd0;
    bus4.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dut4", sample(1'b0), 0);
    chk("reset_dut2", sample(1'b1), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", sample(1'b0), 0);

    faults = 3'b000; do_run(1'b0, 4, 1'b0);
    faults = 3'b001; do_run(1'b0, 4, 1'b0);
    faults = 3'b010; do_run(1'b0, 4, 1'b0);
    // back-to-back runs with start held high
    faults = 3'b110; do_run(1'b0, 4, 1'b1);
    faults = 3'b000; do_run(1'b0, 4, 1'b0);

    // reset during vector 2
    set_start(1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) set_start(1'b0, 1'b0);
    end
    o = sample(1'b0);
    chk("pre_rst_vec", o.vec_idx, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_run_reset", sample(1'b0), 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      o = sample(1'b0);
      chk("no_done_after_rst", {o.done, o.busy}, 0);
    end
    do_run(1'b0, 4, 1'b0);

    faults = 3'b000; do_run(1'b1, 2, 1'b0);
    faults = 3'b001; do_run(1'b1, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
